mac_fetch: RTL and testbench

MAC_FETCH -- requirements
Module: mac_fetch

---
 rtl/mac_fetch_if.sv | 25 ++
 rtl/mac_fetch.sv | 164 ++++++++++++++++
 tb/tb_mac_fetch.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_fetch_if.sv
// Read-bus bundle between the MAC operand fetcher and memory.
// The fetcher is master; the memory side is slave.
interface mac_fetch_if;
  logic [31:0] bus_a;
  logic [3:0]  bus_ba;
  logic        bus_req;
  logic        bus_busy;
  logic [31:0] bus_di;

  modport master (
    output bus_a,
    output bus_ba,
    output bus_req,
    input  bus_busy,
    input  bus_di
  );

  modport slave (
    input  bus_a,
    input  bus_ba,
    input  bus_req,
    output bus_busy,
    output bus_di
  );
endinterface

// File: rtl/mac_fetch.sv
// MAC operand fetcher: reads Rn and Rm operands, hands them to the
// MAC unit one at a time and returns post-incremented pointers.
module mac_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_r,
  input  logic        start,
  input  logic        op_l,
  input  logic        sat,
  input  logic        same_reg,
  input  logic [31:0] rn_addr,
  input  logic [31:0] rm_addr,
  mac_fetch_if.master bus,
  output logic [1:0]  mac_sel,
  output logic [3:0]  mac_op,
  output logic        mac_s,
  output logic        mac_we,
  output logic [31:0] mac_a,
  output logic [31:0] mac_do,
  output logic [31:0] rn_next,
  output logic [31:0] rm_next,
  output logic        wb_en,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    RD_N,
    WR_N,
    RD_M,
    WR_M,
    FIN
  } state_t;

  state_t      state;
  logic        lng;
  logic        same;
  logic [31:0] rn;
  logic [31:0] rm;

  logic [31:0] sz;
  logic [31:0] rn_sz;
  logic [31:0] rn_sz2;
  logic [31:0] rm_sz;
  logic [31:0] m_addr;
  logic [3:0]  op_code;
  logic        mis_n;
  logic        mis_m;
  logic        mis;

  function automatic logic [3:0] lanes(input logic l, input logic a1);
    if (l) return 4'b1111;
    return a1 ? 4'b0011 : 4'b1100;
  endfunction

  // Operand size, address arithmetic and alignment of the requested pointers.
  always_comb begin
    sz      = lng ? 32'd4 : 32'd2;
    rn_sz   = rn + sz;
    rn_sz2  = rn_sz + sz;
    rm_sz   = rm + sz;
    m_addr  = same ? rn_sz : rm;
    op_code = lng ? 4'b1001 : 4'b1011;
    mis_n   = op_l ? (rn_addr[1:0] != 2'b00) : rn_addr[0];
    mis_m   = op_l ? (rm_addr[1:0] != 2'b00) : rm_addr[0];
    mis     = mis_n | (mis_m & ~same_reg);
  end

  // Fetch sequencer; every output is registered and frozen while ce_r=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lng         <= 1'b0;
      same        <= 1'b0;
      rn          <= '0;
      rm          <= '0;
      bus.bus_a   <= '0;
      bus.bus_ba  <= '0;
      bus.bus_req <= 1'b0;
      mac_sel     <= '0;
      mac_op      <= '0;
      mac_s       <= 1'b0;
      mac_we      <= 1'b0;
      mac_a       <= '0;
      mac_do      <= '0;
      rn_next     <= '0;
      rm_next     <= '0;
      wb_en       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else if (ce_r) begin
      err     <= 1'b0;
      done    <= 1'b0;
      wb_en   <= 1'b0;
      mac_we  <= 1'b0;
      mac_sel <= '0;
      mac_op  <= '0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (mis) begin
              err <= 1'b1;
            end else begin
              lng         <= op_l;
              same        <= same_reg;
              rn          <= rn_addr;
              rm          <= rm_addr;
              mac_s       <= sat;
              busy        <= 1'b1;
              bus.bus_req <= 1'b1;
              bus.bus_a   <= rn_addr;
              bus.bus_ba  <= lanes(op_l, rn_addr[1]);
              state       <= RD_N;
            end
          end
        end
        RD_N: begin
          if (!bus.bus_busy) begin
            bus.bus_req <= 1'b0;
            mac_do      <= bus.bus_di;
            mac_a       <= rn;
            mac_we      <= 1'b1;
            mac_sel     <= 2'b01;
            mac_op      <= op_code;
            state       <= WR_N;
          end
        end
        WR_N: begin
          bus.bus_req <= 1'b1;
          bus.bus_a   <= m_addr;
          bus.bus_ba  <= lanes(lng, m_addr[1]);
          state       <= RD_M;
        end
        RD_M: begin
          if (!bus.bus_busy) begin
            bus.bus_req <= 1'b0;
            mac_do      <= bus.bus_di;
            mac_a       <= m_addr;
            mac_we      <= 1'b1;
            mac_sel     <= 2'b10;
            mac_op      <= op_code;
            state       <= WR_M;
          end
        end
        WR_M: begin
          done    <= 1'b1;
          wb_en   <= 1'b1;
          rn_next <= same ? rn_sz2 : rn_sz;
          rm_next <= same ? rn_sz2 : rm_sz;
          state   <= FIN;
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_fetch.sv
// Directed bench for mac_fetch: vector table of complete fetches plus
// hand sequences for errors, reset mid-operation and clock-enable stalls.
module tb_mac_fetch;

  logic        clk;
  logic        rst;
  logic        ce_r;
  logic        start;
  logic        op_l;
  logic        sat;
  logic        same_reg;
  logic [31:0] rn_addr;
  logic [31:0] rm_addr;
  logic [1:0]  mac_sel;
  logic [3:0]  mac_op;
  logic        mac_s;
  logic        mac_we;
  logic [31:0] mac_a;
  logic [31:0] mac_do;
  logic [31:0] rn_next;
  logic [31:0] rm_next;
  logic        wb_en;
  logic        busy;
  logic        done;
  logic        err;

  int ntests = 0;
  int nfail  = 0;

  mac_fetch_if bus ();

  mac_fetch dut (
    .clk      (clk),
    .rst      (rst),
    .ce_r     (ce_r),
    .start    (start),
    .op_l     (op_l),
    .sat      (sat),
    .same_reg (same_reg),
    .rn_addr  (rn_addr),
    .rm_addr  (rm_addr),
    .bus      (bus),
    .mac_sel  (mac_sel),
    .mac_op   (mac_op),
    .mac_s    (mac_s),
    .mac_we   (mac_we),
    .mac_a    (mac_a),
    .mac_do   (mac_do),
    .rn_next  (rn_next),
    .rm_next  (rm_next),
    .wb_en    (wb_en),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        op_l;
    logic        same;
    logic        sat;
    logic        poke;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [31:0] d0;
    logic [31:0] d1;
    int          waits;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [3:0]  ba0;
    logic [3:0]  ba1;
    logic [3:0]  op;
    logic [31:0] rn_nx;
    logic [31:0] rm_nx;
    int          done_cyc;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] fa0, fa1, ma0, ma1, md0, md1, rnn, rmn;
    logic [3:0]  fba0, fba1, op0, op1, ba_wm;
    logic        s0, wb;
    bit          got0, got1, seen0, ovl, moved, idle_busy;
    int          wl, dc, cyc, nwe;
    string       p;
    p = $sformatf("v%0d_", idx);
    {fa0, fa1, ma0, ma1, md0, md1, rnn, rmn} = '0;
    {fba0, fba1, op0, op1, ba_wm} = '0;
    {s0, wb} = '0;
    {got0, got1, seen0, ovl, moved, idle_busy} = '0;
    dc = 0;
    nwe = 0;
    wl = v.waits;
    @(negedge clk);
    start    = 1'b1;
    op_l     = v.op_l;
    sat      = v.sat;
    same_reg = v.same;
    rn_addr  = v.rn;
    rm_addr  = v.rm;
    bus.bus_di   = v.d0;
    bus.bus_busy = 1'b0;
    @(negedge clk);
    rn_addr = 32'h0000_7770;
    rm_addr = 32'h0000_8880;
    sat     = ~v.sat;
    cyc = 1;
    while (dc == 0 && cyc <= 30) begin
      start = 1'b0;
      if (!busy) idle_busy = 1;
      if (bus.bus_req && mac_we) ovl = 1;
      if (bus.bus_req) begin
        if (!seen0) begin
          if (!got0) begin
            fa0 = bus.bus_a; fba0 = bus.bus_ba; got0 = 1;
          end else if (bus.bus_a !== fa0 || bus.bus_ba !== fba0) begin
            moved = 1;
          end
          bus.bus_di = v.d0;
          if (wl > 0) begin bus.bus_busy = 1'b1; wl--; end
          else bus.bus_busy = 1'b0;
        end else begin
          if (!got1) begin
            fa1 = bus.bus_a; fba1 = bus.bus_ba; got1 = 1;
          end
          bus.bus_di   = v.d1;
          bus.bus_busy = 1'b0;
        end
      end else begin
        bus.bus_busy = 1'b0;
      end
      if (mac_we) nwe++;
      if (mac_we && mac_sel == 2'b01) begin
        seen0 = 1; ma0 = mac_a; md0 = mac_do; op0 = mac_op; s0 = mac_s;
        if (v.poke) start = 1'b1;
      end
      if (mac_we && mac_sel == 2'b10) begin
        ma1 = mac_a; md1 = mac_do; op1 = mac_op; ba_wm = bus.bus_ba;
      end
      if (done) begin
        dc = cyc; rnn = rn_next; rmn = rm_next; wb = wb_en;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk({p, "done_cyc"}, dc, v.done_cyc);
    chk({p, "rd0_addr"}, fa0, v.a0);
    chk({p, "rd0_ba"}, {28'd0, fba0}, {28'd0, v.ba0});
    chk({p, "rd0_stable"}, {31'd0, moved}, 32'd0);
    chk({p, "rd1_addr"}, fa1, v.a1);
    chk({p, "rd1_ba"}, {28'd0, fba1}, {28'd0, v.ba1});
    chk({p, "wm_ba"}, {28'd0, ba_wm}, {28'd0, v.ba1});
    chk({p, "mac_a0"}, ma0, v.a0);
    chk({p, "mac_do0"}, md0, v.d0);
    chk({p, "mac_op0"}, {28'd0, op0}, {28'd0, v.op});
    chk({p, "mac_s"}, {31'd0, s0}, {31'd0, v.sat});
    chk({p, "mac_a1"}, ma1, v.a1);
    chk({p, "mac_do1"}, md1, v.d1);
    chk({p, "mac_op1"}, {28'd0, op1}, {28'd0, v.op});
    chk({p, "we_count"}, nwe, 2);
    chk({p, "req_we_overlap"}, {31'd0, ovl}, 32'd0);
    chk({p, "busy_gap"}, {31'd0, idle_busy}, 32'd0);
    chk({p, "rn_next"}, rnn, v.rn_nx);
    chk({p, "rm_next"}, rmn, v.rm_nx);
    chk({p, "wb_en"}, {31'd0, wb}, 32'd1);
    @(negedge clk);
    chk({p, "done_pulse"}, {31'd0, done}, 32'd0);
    chk({p, "wb_pulse"}, {31'd0, wb_en}, 32'd0);
    @(negedge clk);
    chk({p, "idle_busy"}, {31'd0, busy}, 32'd0);
    chk({p, "idle_req"}, {31'd0, bus.bus_req}, 32'd0);
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_2002,
              32'hAAAA_5555, 32'h1234_8000, 0, 32'h0000_1000,
              32'h0000_2002, 4'b1100, 4'b0011, 4'b1011,
              32'h0000_1002, 32'h0000_2004, 5};
    vt[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_4000, 32'h9999_0001,
              32'hDEAD_BEEF, 32'h0123_4567, 0, 32'h0000_4000,
              32'h0000_4004, 4'b1111, 4'b1111, 4'b1001,
              32'h0000_4008, 32'h0000_4008, 5};
    vt[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0200,
              32'h1111_1111, 32'h2222_2222, 3, 32'h0000_0100,
              32'h0000_0200, 4'b1111, 4'b1111, 4'b1001,
              32'h0000_0104, 32'h0000_0204, 8};
    vt[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0010,
              32'h5A5A_0000, 32'h0000_A5A5, 0, 32'hFFFF_FFFE,
              32'h0000_0010, 4'b0011, 4'b1100, 4'b1011,
              32'h0000_0000, 32'h0000_0012, 5};
    vt[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0003,
              32'hCAFE_0001, 32'h0002_BABE, 1, 32'hFFFF_FFFC,
              32'hFFFF_FFFE, 4'b1100, 4'b0011, 4'b1011,
              32'h0000_0000, 32'h0000_0000, 6};

    rst = 1'b1;
    ce_r = 1'b1;
    start = 1'b0;
    op_l = 1'b0;
    sat = 1'b0;
    same_reg = 1'b0;
    rn_addr = '0;
    rm_addr = '0;
    bus.bus_busy = 1'b0;
    bus.bus_di = '0;

    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req", {31'd0, bus.bus_req}, 32'd0);
    chk("rst_bus_a", bus.bus_a, 32'd0);
    chk("rst_mac_do", mac_do, 32'd0);
    chk("rst_flags", {27'd0, mac_we, wb_en, done, err, mac_s}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(i, vt[i]);

    // misaligned RM on MAC.L
    @(negedge clk);
    start = 1'b1; op_l = 1'b1; same_reg = 1'b0;
    rn_addr = 32'h0000_0000; rm_addr = 32'h0000_0102;
    @(negedge clk);
    start = 1'b0;
    chk("err_l_pulse", {31'd0, err}, 32'd1);
    chk("err_l_busy", {31'd0, busy}, 32'd0);
    chk("err_l_req", {31'd0, bus.bus_req}, 32'd0);
    @(negedge clk);
    chk("err_l_clear", {31'd0, err}, 32'd0);
    chk("err_l_req2", {30'd0, bus.bus_req, mac_we}, 32'd0);

    // odd RN on MAC.W
    start = 1'b1; op_l = 1'b0; rn_addr = 32'h0000_1001; rm_addr = 32'h0;
    @(negedge clk);
    start = 1'b0;
    chk("err_w_pulse", {31'd0, err}, 32'd1);
    chk("err_w_busy", {30'd0, busy, bus.bus_req}, 32'd0);
    @(negedge clk);
    chk("err_w_clear", {31'd0, err}, 32'd0);

    // reset while waiting in RD_M
    start = 1'b1; op_l = 1'b0; same_reg = 1'b0;
    rn_addr = 32'h0000_1000; rm_addr = 32'h0000_2002;
    bus.bus_di = 32'h1357_9BDF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.bus_busy = 1'b1;
    chk("rdm_req", {31'd0, bus.bus_req}, 32'd1);
    chk("rdm_addr", bus.bus_a, 32'h0000_2002);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", {31'd0, bus.bus_req}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_bus_a", bus.bus_a, 32'd0);
    chk("arst_mac_do", mac_do, 32'd0);
    chk("arst_mac_a", mac_a, 32'd0);
    chk("arst_misc", {22'd0, bus.bus_ba, mac_sel, mac_op}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.bus_busy = 1'b0;
    @(negedge clk);
    chk("post_rst_req", {31'd0, bus.bus_req}, 32'd0);
    chk("post_rst_we", {30'd0, mac_we, busy}, 32'd0);
    run_vec(5, vt[0]);

    // clock-enable stalls hold request, write strobe and done
    @(negedge clk);
    start = 1'b1; op_l = 1'b1; same_reg = 1'b0;
    rn_addr = 32'h0000_3000; rm_addr = 32'h0000_3100;
    bus.bus_di = 32'h0F0F_0F0F;
    @(negedge clk);
    start = 1'b0;
    ce_r = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ce_req_hold", {31'd0, bus.bus_req}, 32'd1);
    chk("ce_addr_hold", bus.bus_a, 32'h0000_3000);
    chk("ce_no_we", {31'd0, mac_we}, 32'd0);
    ce_r = 1'b1;
    @(negedge clk);
    chk("ce_we_on", {31'd0, mac_we}, 32'd1);
    ce_r = 1'b0;
    @(negedge clk);
    chk("ce_we_hold", {29'd0, mac_we, mac_sel}, 32'd5);
    chk("ce_do_hold", mac_do, 32'h0F0F_0F0F);
    ce_r = 1'b1;
    begin
      int n;
      n = 0;
      while (!done && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("ce_done_seen", {31'd0, done}, 32'd1);
    end
    ce_r = 1'b0;
    @(negedge clk);
    chk("ce_done_hold", {30'd0, done, wb_en}, 32'd3);
    chk("ce_rn_next", rn_next, 32'h0000_3004);
    ce_r = 1'b1;
    @(negedge clk);
    chk("ce_done_drop", {31'd0, done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
